apu_frame_sequencer: RTL and testbench

Timing generator for the APU: it divides the 4 MiHz `nphi` clock into the 1 MHz and 512 kHz square enables, and edge-detects the DIV 512 Hz tap to step the 8-step frame sequencer. It produces the 512 Hz and 128 Hz levels plus single-cycle length, sweep and envelope ticks. It sits directly upstream of the four channel blocks, including channel 4, which consume `bavu_1mhz`, `hama_512k`, `jeso_512k`, `horu_512hz` and `byfe_128hz`.

---
 rtl/apu_frame_sequencer.sv | 102 ++++++++++
 tb/tb_apu_frame_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/apu_frame_sequencer.sv
// APU timing generator: 1 MHz / 512 kHz prescaler enables and 8-step frame sequencer.
// Optional APU_FRAME_FAST_EN adds fast_frame, which steps the sequencer every 16 cycles.
module apu_frame_sequencer (
  input  logic       nphi,
  input  logic       napu_reset,
  input  logic       apu_en,
  input  logic       div_512hz,
`ifdef APU_FRAME_FAST_EN
  input  logic       fast_frame,
`endif
  output logic       bavu_1mhz,
  output logic       hama_512k,
  output logic       jeso_512k,
  output logic       horu_512hz,
  output logic       byfe_128hz,
  output logic [2:0] frame_step,
  output logic       len_tick,
  output logic       sweep_tick,
  output logic       env_tick
);

  logic [2:0] pre;
  logic       div_q;
  logic       horu_q;
  logic [2:0] step_q;
  logic       len_q;
  logic       sweep_q;
  logic       env_q;
  logic       frame_tick;

`ifdef APU_FRAME_FAST_EN
  logic [3:0] fast_cnt;
  logic       fast_active;

  assign fast_active = apu_en & fast_frame;

  always_ff @(posedge nphi) begin
    if (!napu_reset || !fast_active) begin
      fast_cnt <= 4'd0;
    end else begin
      fast_cnt <= fast_cnt + 4'd1;
    end
  end

  always_comb begin
    frame_tick = 1'b0;
    if (fast_active) begin
      frame_tick = (fast_cnt == 4'hf);
    end else begin
      frame_tick = div_q & ~div_512hz;
    end
  end
`else
  always_comb begin
    frame_tick = 1'b0;
    frame_tick = div_q & ~div_512hz;
  end
`endif

  // div_q keeps tracking while disabled so a level already low at enable is not an edge
  always_ff @(posedge nphi) begin
    if (!napu_reset) begin
      pre     <= 3'd0;
      div_q   <= 1'b0;
      horu_q  <= 1'b0;
      step_q  <= 3'd0;
      len_q   <= 1'b0;
      sweep_q <= 1'b0;
      env_q   <= 1'b0;
    end else begin
      div_q <= div_512hz;
      if (!apu_en) begin
        pre     <= 3'd0;
        horu_q  <= 1'b0;
        step_q  <= 3'd0;
        len_q   <= 1'b0;
        sweep_q <= 1'b0;
        env_q   <= 1'b0;
      end else begin
        pre     <= pre + 3'd1;
        horu_q  <= div_512hz;
        len_q   <= frame_tick & ~step_q[0];
        sweep_q <= frame_tick & (step_q[1:0] == 2'b10);
        env_q   <= frame_tick & (step_q == 3'd7);
        if (frame_tick) begin
          step_q <= step_q + 3'd1;
        end
      end
    end
  end

  assign bavu_1mhz  = pre[1];
  assign hama_512k  = pre[2];
  assign jeso_512k  = pre[2] ^ pre[1];
  assign horu_512hz = horu_q;
  assign byfe_128hz = step_q[1];
  assign frame_step = step_q;
  assign len_tick   = len_q;
  assign sweep_tick = sweep_q;
  assign env_tick   = env_q;

endmodule

// File: tb/tb_apu_frame_sequencer.sv
// Self-checking bench for apu_frame_sequencer: per-cycle scoreboard against a behavioural
// model plus directed checks of the frame sequence, disable/enable and reset cases.
module tb_apu_frame_sequencer;

  logic       nphi;
  logic       napu_reset;
  logic       apu_en;
  logic       div_512hz;
`ifdef APU_FRAME_FAST_EN
  logic       fast_frame;
`endif
  logic       bavu_1mhz, hama_512k, jeso_512k, horu_512hz, byfe_128hz;
  logic [2:0] frame_step;
  logic       len_tick, sweep_tick, env_tick;

  int checks = 0;
  int errors = 0;

  logic [10:0] sb_q[$];

  logic [2:0] m_pre, m_step;
  logic       m_divq, m_horu, m_len, m_sweep, m_env;
  int         m_fcnt;

  apu_frame_sequencer dut (
    .nphi       (nphi),
    .napu_reset (napu_reset),
    .apu_en     (apu_en),
    .div_512hz  (div_512hz),
`ifdef APU_FRAME_FAST_EN
    .fast_frame (fast_frame),
`endif
    .bavu_1mhz  (bavu_1mhz),
    .hama_512k  (hama_512k),
    .jeso_512k  (jeso_512k),
    .horu_512hz (horu_512hz),
    .byfe_128hz (byfe_128hz),
    .frame_step (frame_step),
    .len_tick   (len_tick),
    .sweep_tick (sweep_tick),
    .env_tick   (env_tick)
  );

  initial nphi = 1'b0;
  always #5 nphi = ~nphi;

  function automatic logic [10:0] observed();
    return {bavu_1mhz, hama_512k, jeso_512k, horu_512hz, byfe_128hz,
            frame_step, len_tick, sweep_tick, env_tick};
  endfunction

  // Advance the model by one edge using the inputs as currently driven, queue the
  // expectation, clock the DUT and compare just after the edge.
  task automatic cyc();
    logic [10:0] e;
    logic [10:0] o;
    logic        tk;
    bit          fast;
    fast = 1'b0;
`ifdef APU_FRAME_FAST_EN
    fast = fast_frame;
`endif
    if (!napu_reset) begin
      m_pre = 0; m_step = 0; m_divq = 0; m_horu = 0;
      m_len = 0; m_sweep = 0; m_env = 0; m_fcnt = 0;
    end else begin
      tk = 1'b0;
      if (apu_en) tk = fast ? (m_fcnt == 15) : (m_divq && !div_512hz);
      m_fcnt = (apu_en && fast) ? (m_fcnt + 1) % 16 : 0;
      m_divq = div_512hz;
      if (!apu_en) begin
        m_pre = 0; m_step = 0; m_horu = 0;
        m_len = 0; m_sweep = 0; m_env = 0;
      end else begin
        m_pre   = m_pre + 3'd1;
        m_horu  = div_512hz;
        m_len   = tk && (m_step % 2 == 0);
        m_sweep = tk && (m_step == 2 || m_step == 6);
        m_env   = tk && (m_step == 7);
        if (tk) m_step = m_step + 3'd1;
      end
    end
    e = {m_pre[1], m_pre[2], m_pre[2] ^ m_pre[1], m_horu, m_step[1],
         m_step, m_len, m_sweep, m_env};
    sb_q.push_back(e);
    @(posedge nphi);
    #1;
    e = sb_q.pop_front();
    o = observed();
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL cycle_model t=%0t observed=%b expected=%b", $time, o, e);
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One DIV period ending on the falling edge: the tick lands on the last cycle.
  task automatic div_fall();
    div_512hz = 1'b1;
    repeat (3) cyc();
    div_512hz = 1'b0;
    cyc();
  endtask

  initial begin
    logic [7:0] bv, hv;
    int         s, changes;
    logic [2:0] prev;
    napu_reset = 1'b0;
    apu_en     = 1'b1;
    div_512hz  = 1'b0;
`ifdef APU_FRAME_FAST_EN
    fast_frame = 1'b0;
`endif
    m_pre = 0; m_step = 0; m_divq = 0; m_horu = 0;
    m_len = 0; m_sweep = 0; m_env = 0; m_fcnt = 0;

    // Reset held with apu_en high
    div_512hz = 1'b1;
    repeat (3) cyc();
    chk("reset_outputs", {5'd0, observed()} == 16'd0 ? 8'd0 : 8'd1, 8'd0);
    div_512hz = 1'b0;

    // Prescaler patterns after release
    napu_reset = 1'b1;
    bv = 8'd0; hv = 8'd0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      bv = {bv[6:0], bavu_1mhz};
      hv = {hv[6:0], hama_512k};
    end
    chk("bavu_pattern", bv, 8'b0110_0110);
    chk("hama_pattern", hv, 8'b0001_1110);

    // Full sequence of eight falling edges
    for (int i = 1; i <= 8; i++) begin
      div_fall();
      s = i % 8;
      chk($sformatf("step_tick%0d", i), {5'd0, frame_step}, 8'(s));
      chk($sformatf("len_tick%0d", i), {7'd0, len_tick}, 8'(i % 2));
      chk($sformatf("sweep_tick%0d", i), {7'd0, sweep_tick}, 8'((i == 3 || i == 7) ? 1 : 0));
      chk($sformatf("env_tick%0d", i), {7'd0, env_tick}, 8'((i == 8) ? 1 : 0));
      chk($sformatf("byfe_tick%0d", i), {7'd0, byfe_128hz}, 8'((s >> 1) & 1));
      cyc();
      chk($sformatf("pulse_drop%0d", i), {5'd0, len_tick, sweep_tick, env_tick}, 8'd0);
    end

    // Disable at step 5
    repeat (5) div_fall();
    chk("step_before_disable", {5'd0, frame_step}, 8'd5);
    apu_en = 1'b0;
    cyc();
    chk("disable_step", {5'd0, frame_step}, 8'd0);
    chk("disable_outputs", {3'd0, bavu_1mhz, hama_512k, jeso_512k, horu_512hz, byfe_128hz}, 8'd0);
    repeat (2) div_fall();
    chk("disable_ignores_div", {5'd0, frame_step}, 8'd0);

    // Re-enable with div already low: no tick until a true edge
    apu_en = 1'b1;
    repeat (6) cyc();
    chk("reenable_no_tick", {5'd0, frame_step}, 8'd0);
    div_fall();
    chk("reenable_first_tick", {5'd0, frame_step}, 8'd1);
    chk("reenable_len", {7'd0, len_tick}, 8'd1);
    cyc();

    // Reset while env_tick is high
    repeat (6) div_fall();
    chk("step_7", {5'd0, frame_step}, 8'd7);
    div_fall();
    chk("env_before_reset", {7'd0, env_tick}, 8'd1);
    napu_reset = 1'b0;
    cyc();
    chk("reset_clears_env", {7'd0, env_tick}, 8'd0);
    chk("reset_step", {5'd0, frame_step}, 8'd0);
    napu_reset = 1'b1;
    repeat (4) cyc();
    chk("no_reissue_env", {7'd0, env_tick}, 8'd0);

`ifdef APU_FRAME_FAST_EN
    // Fast mode: eight ticks in 128 cycles, DIV edges ignored
    fast_frame = 1'b1;
    changes = 0;
    prev = frame_step;
    for (int i = 0; i < 128; i++) begin
      div_512hz = (i % 6) < 3;
      cyc();
      if (frame_step != prev) changes++;
      prev = frame_step;
    end
    chk("fast_tick_count", 8'(changes), 8'd8);
    chk("fast_step_wrap", {5'd0, frame_step}, 8'd0);
    fast_frame = 1'b0;
    div_512hz = 1'b0;
    repeat (4) cyc();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
